// File: rtl/stage_voice_mixer_pkg.sv
// Shared types and constants for the voice mixer stage.
package stage_voice_mixer_pkg;

    localparam int unsigned NUM_VOICE_OPERATORS = 256;
    localparam int unsigned VOICE_OP_ID_WIDTH   = $clog2(NUM_VOICE_OPERATORS);
    localparam int unsigned SAMPLE_WIDTH        = 16;
    localparam int unsigned ACC_WIDTH           = 24;
    localparam int unsigned OUTPUT_SHIFT        = 3;

    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MAX = 16'sh7fff;
    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MIN = 16'sh8000;

    // Saturation bounds sign-extended to accumulator width
    localparam logic signed [ACC_WIDTH-1:0] ACC_SAMPLE_MAX = ACC_WIDTH'(SAMPLE_MAX);
    localparam logic signed [ACC_WIDTH-1:0] ACC_SAMPLE_MIN = ACC_WIDTH'(SAMPLE_MIN);

    typedef logic [VOICE_OP_ID_WIDTH-1:0] VoiceOperatorID_t;

    // Only the carrier flag of the algorithm word matters at this stage
    typedef struct packed {
        logic IsCarrier;
    } AlgorithmWord_t;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    // Arithmetic scale-down of a frame sum followed by clamp to the sample range
    function automatic logic signed [SAMPLE_WIDTH-1:0] scale_saturate(
        input logic signed [ACC_WIDTH-1:0] sum
    );
        logic signed [ACC_WIDTH-1:0] scaled;
        scaled = sum >>> OUTPUT_SHIFT;
        if (scaled > ACC_SAMPLE_MAX) begin
            return SAMPLE_MAX;
        end else if (scaled < ACC_SAMPLE_MIN) begin
            return SAMPLE_MIN;
        end
        return scaled[SAMPLE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/stage_voice_mixer_fifo.sv
// Two-entry sample FIFO with registered head; reports pushes dropped while full.
module sample_fifo2
    import stage_voice_mixer_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic signed [SAMPLE_WIDTH-1:0] data_i,
    input  logic                           ready_i,
    output logic signed [SAMPLE_WIDTH-1:0] data_o,
    output logic                           valid_o,
    output logic                           drop_c_o
);

    logic [1:0]                     count_q, count_d;
    logic signed [SAMPLE_WIDTH-1:0] head_q, head_d;
    logic signed [SAMPLE_WIDTH-1:0] tail_q, tail_d;
    logic                           valid_q, valid_d;
    logic                           pop_c;
    logic                           drop_c;

    assign pop_c = valid_q & ready_i;

    // Next contents: head always holds the oldest entry, zero when empty
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drop_c  = 1'b0;
        case (count_q)
            2'd0: begin
                if (push_i) begin
                    head_d  = data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_c) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d  = data_i;
                    count_d = 2'd2;
                end else if (pop_c) begin
                    head_d  = '0;
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (push_i && pop_c) begin
                    head_d = tail_q;
                    tail_d = data_i;
                end else if (pop_c) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    count_d = 2'd1;
                end else if (push_i) begin
                    drop_c = 1'b1;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = 2'd0;
            end
        endcase
        valid_d = (count_d != 2'd0);
    end

    // Storage registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    assign data_o   = head_q;
    assign valid_o  = valid_q;
    assign drop_c_o = drop_c;

endmodule

// File: rtl/stage_voice_mixer.sv
// Final stage: sums carrier outputs of each operator frame into one saturated audio sample.
module stage_voice_mixer
    import stage_voice_mixer_pkg::*;
(
    input  logic                           i_Clock,
    input  logic                           i_Reset_n,
    input  VoiceOperatorID_t               i_VoiceOperator,
    input  AlgorithmWord_t                 i_AlgorithmWord,
    input  logic signed [SAMPLE_WIDTH-1:0] i_Waveform,
    output logic signed [SAMPLE_WIDTH-1:0] o_Sample,
    output logic                           o_SampleValid,
    input  logic                           i_SampleReady,
    output logic                           o_Overrun,
    output logic                           o_FrameError
);

    localparam VoiceOperatorID_t LAST_ID = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

    lock_state_e                 state_q, state_d;
    VoiceOperatorID_t            prev_id_q;
    VoiceOperatorID_t            expected_id_c;
    logic                        accept_c;
    logic                        mismatch_c;
    logic                        first_id_c;
    logic signed [ACC_WIDTH-1:0] term_c;
    logic signed [ACC_WIDTH-1:0] frame_sum_c;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] commit_q;
    logic                        commit_valid_q;
    logic                        overrun_q;
    logic                        frame_error_q;
    logic                        fifo_drop_c;

    assign expected_id_c = (prev_id_q == LAST_ID) ? '0 : prev_id_q + VoiceOperatorID_t'(1);
    assign first_id_c    = (i_VoiceOperator == '0);
    assign term_c        = i_AlgorithmWord.IsCarrier
                         ? {{(ACC_WIDTH-SAMPLE_WIDTH){i_Waveform[SAMPLE_WIDTH-1]}}, i_Waveform}
                         : '0;
    assign frame_sum_c   = first_id_c ? term_c : acc_q + term_c;

    // Frame-lock state register
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q <= LOCK_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame-lock next state: lock on ID 0, drop lock on any out-of-sequence ID
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOCK_UNLOCKED: if (first_id_c) state_d = LOCK_LOCKED;
            LOCK_LOCKED:   if (i_VoiceOperator != expected_id_c) state_d = LOCK_UNLOCKED;
        endcase
    end

    // Frame-lock outputs: which input words are accumulated or flagged
    always_comb begin
        accept_c   = 1'b0;
        mismatch_c = 1'b0;
        unique case (state_q)
            LOCK_UNLOCKED: accept_c = first_id_c;
            LOCK_LOCKED: begin
                if (i_VoiceOperator == expected_id_c) begin
                    accept_c = 1'b1;
                end else begin
                    mismatch_c = 1'b1;
                end
            end
        endcase
    end

    // Accumulator, frame commit and sticky status flags
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            prev_id_q      <= '0;
            acc_q          <= '0;
            commit_q       <= '0;
            commit_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            commit_valid_q <= 1'b0;
            if (mismatch_c) begin
                acc_q         <= '0;
                frame_error_q <= 1'b1;
            end else if (accept_c) begin
                prev_id_q <= i_VoiceOperator;
                acc_q     <= frame_sum_c;
                if (i_VoiceOperator == LAST_ID) begin
                    commit_q       <= frame_sum_c;
                    commit_valid_q <= 1'b1;
                end
            end
            if (fifo_drop_c) begin
                overrun_q <= 1'b1;
            end
        end
    end

    sample_fifo2 u_fifo (
        .clk_i    (i_Clock),
        .rst_ni   (i_Reset_n),
        .push_i   (commit_valid_q),
        .data_i   (scale_saturate(commit_q)),
        .ready_i  (i_SampleReady),
        .data_o   (o_Sample),
        .valid_o  (o_SampleValid),
        .drop_c_o (fifo_drop_c)
    );

    assign o_Overrun    = overrun_q;
    assign o_FrameError = frame_error_q;

endmodule
